// File: rtl/mem_reg_bank_if.sv
// Bus bundle for mem_reg_bank: bank write/read ports, aux registers and scrub control.
// The master side drives requests, and the slave side returns read data and status.
interface mem_reg_bank_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 5,
  parameter int NAUX   = 2
) ();
  logic                   write;
  logic [ADDR_W-1:0]      dira;
  logic [ADDR_W-1:0]      dirb;
  logic [DATA_W-1:0]      data;
  logic [DATA_W-1:0]      A;
  logic [DATA_W-1:0]      B;
  logic [NAUX-1:0]        aux_we;
  logic [NAUX*DATA_W-1:0] aux_d;
  logic [NAUX*DATA_W-1:0] aux_q;
  logic                   clear;
  logic                   busy;

  modport master (
    output write, dira, dirb, data, aux_we, aux_d, clear,
    input  A, B, aux_q, busy
  );

  modport slave (
    input  write, dira, dirb, data, aux_we, aux_d, clear,
    output A, B, aux_q, busy
  );
endinterface

// File: rtl/mem_reg_bank.sv
// Two-read-port register bank with write-first bypass, a sequential zero-scrub engine,
// and independent auxiliary registers. Reset clears every word, so the bank is built from flops.
module mem_reg_bank #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 5,
  parameter int NAUX   = 2
) (
  input logic          clk,
  input logic          rst_n,
  mem_reg_bank_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {IDLE, SCRUB} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   cnt_reg;
  logic                busy_reg;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   b_reg;
  logic [DATA_W-1:0]   mem_reg [DEPTH];
  logic [NAUX*DATA_W-1:0] aux_q_flat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.write) begin
            mem_reg[bus.dira] <= bus.data;
            a_reg             <= bus.data;
            b_reg             <= (bus.dirb == bus.dira) ? bus.data : mem_reg[bus.dirb];
          end else begin
            a_reg <= mem_reg[bus.dira];
            b_reg <= mem_reg[bus.dirb];
          end
          if (bus.clear) begin
            state_reg <= SCRUB;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        SCRUB: begin
          // Reads see the array before this edge's zero lands, so the scrubbed slot returns its old value once.
          mem_reg[cnt_reg] <= '0;
          a_reg            <= mem_reg[bus.dira];
          b_reg            <= mem_reg[bus.dirb];
          if (cnt_reg == LAST_ADDR) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + ADDR_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NAUX; gi++) begin : g_aux
      logic [DATA_W-1:0] q_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if (bus.aux_we[gi]) begin
          q_reg <= bus.aux_d[gi*DATA_W +: DATA_W];
        end
      end

      assign aux_q_flat[gi*DATA_W +: DATA_W] = q_reg;
    end
  endgenerate

  assign bus.A     = a_reg;
  assign bus.B     = b_reg;
  assign bus.busy  = busy_reg;
  assign bus.aux_q = aux_q_flat;
endmodule

// File: tb/tb_mem_reg_bank.sv
// Directed bench for mem_reg_bank: a vector table for write/read/bypass/aux behaviour,
// then hand sequences for scrub, reset during scrub, and a small-parameter instance.
module tb_mem_reg_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_reg_bank_if #(.DATA_W(24), .ADDR_W(5), .NAUX(2)) bus ();
  mem_reg_bank_if #(.DATA_W(16), .ADDR_W(3), .NAUX(4)) bus2 ();

  mem_reg_bank #(.DATA_W(24), .ADDR_W(5), .NAUX(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  mem_reg_bank #(.DATA_W(16), .ADDR_W(3), .NAUX(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  typedef struct {
    logic        write;
    logic [4:0]  dira;
    logic [4:0]  dirb;
    logic [23:0] data;
    logic [1:0]  aux_we;
    logic [47:0] aux_d;
    logic [23:0] exp_a;
    logic [23:0] exp_b;
    logic [47:0] exp_aux;
  } vec_t;

  vec_t vecs [10];
  logic [23:0] mdl [32];
  int checks = 0;
  int errors = 0;
  int busy_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd3,  5'd0,  24'hABCDEF, 2'b00, 48'h0, 24'hABCDEF, 24'h000000, 48'h0};
    vecs[1] = '{1'b0, 5'd3,  5'd3,  24'h000000, 2'b00, 48'h0, 24'hABCDEF, 24'hABCDEF, 48'h0};
    vecs[2] = '{1'b1, 5'd8,  5'd3,  24'h888888, 2'b00, 48'h0, 24'h888888, 24'hABCDEF, 48'h0};
    vecs[3] = '{1'b1, 5'd7,  5'd7,  24'h123456, 2'b00, 48'h0, 24'h123456, 24'h123456, 48'h0};
    vecs[4] = '{1'b1, 5'd7,  5'd8,  24'h654321, 2'b00, 48'h0, 24'h654321, 24'h888888, 48'h0};
    vecs[5] = '{1'b0, 5'd7,  5'd3,  24'h000000, 2'b10, 48'h112233_445566,
                24'h654321, 24'hABCDEF, 48'h112233_000000};
    vecs[6] = '{1'b0, 5'd8,  5'd7,  24'h000000, 2'b01, 48'hFFFFFF_445566,
                24'h888888, 24'h654321, 48'h112233_445566};
    vecs[7] = '{1'b1, 5'd3,  5'd3,  24'h000001, 2'b11, 48'hAAAAAA_BBBBBB,
                24'h000001, 24'h000001, 48'hAAAAAA_BBBBBB};
    vecs[8] = '{1'b0, 5'd31, 5'd0,  24'h000000, 2'b00, 48'h0, 24'h000000, 24'h000000, 48'hAAAAAA_BBBBBB};
    vecs[9] = '{1'b1, 5'd31, 5'd31, 24'hFFFFFF, 2'b00, 48'h0, 24'hFFFFFF, 24'hFFFFFF, 48'hAAAAAA_BBBBBB};

    bus.write = 0; bus.dira = '0; bus.dirb = '0; bus.data = '0;
    bus.aux_we = '0; bus.aux_d = '0; bus.clear = 0;
    bus2.write = 0; bus2.dira = '0; bus2.dirb = '0; bus2.data = '0;
    bus2.aux_we = '0; bus2.aux_d = '0; bus2.clear = 0;

    #3;
    chk("reset_A", 64'(bus.A), 64'h0);
    chk("reset_B", 64'(bus.B), 64'h0);
    chk("reset_aux", 64'(bus.aux_q), 64'h0);
    chk("reset_busy", 64'(bus.busy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      bus.write = vecs[v].write; bus.dira = vecs[v].dira; bus.dirb = vecs[v].dirb;
      bus.data = vecs[v].data; bus.aux_we = vecs[v].aux_we; bus.aux_d = vecs[v].aux_d;
      step();
      $display("vec %0d A=%h B=%h aux_q=%h", v, bus.A, bus.B, bus.aux_q);
      chk($sformatf("vec%0d_A", v), 64'(bus.A), 64'(vecs[v].exp_a));
      chk($sformatf("vec%0d_B", v), 64'(bus.B), 64'(vecs[v].exp_b));
      chk($sformatf("vec%0d_aux", v), 64'(bus.aux_q), 64'(vecs[v].exp_aux));
    end
    bus.aux_we = '0;

    // Fill every word with a nonzero pattern.
    for (int i = 0; i < 32; i++) begin
      mdl[i] = 24'((i + 1) * 24'h010101);
      bus.write = 1; bus.dira = 5'(i); bus.dirb = 5'(i); bus.data = mdl[i];
      step();
      chk($sformatf("fill%0d_A", i), 64'(bus.A), 64'(mdl[i]));
    end

    bus.write = 0; bus.clear = 1; bus.dira = '0; bus.dirb = '0;
    step();
    $display("clear accepted busy=%0b", bus.busy);
    chk("scrub_busy_start", 64'(bus.busy), 64'h1);
    bus.clear = 0;
    busy_cnt = 1;
    for (int j = 0; j < 32; j++) begin
      logic [23:0] exp_a;
      logic [23:0] exp_b;
      bus.write = 0; bus.aux_we = '0; bus.clear = (j == 10);
      bus.dira = 5'(j);
      bus.dirb = (j == 0) ? 5'd31 : 5'(j - 1);
      exp_a = mdl[j];
      exp_b = (j == 0) ? mdl[31] : 24'h0;
      if (j == 5) begin
        bus.write = 1; bus.dira = 5'd31; bus.data = 24'hFFFFFF;
        bus.aux_we = 2'b01; bus.aux_d = 48'h777777_000055;
        exp_a = mdl[31];
      end
      step();
      chk($sformatf("scrub%0d_A", j), 64'(bus.A), 64'(exp_a));
      chk($sformatf("scrub%0d_B", j), 64'(bus.B), 64'(exp_b));
      if (j == 5) chk("scrub_aux", 64'(bus.aux_q), 64'hAAAAAA_000055);
      if (bus.busy) busy_cnt++;
    end
    bus.write = 0; bus.aux_we = '0; bus.clear = 0;
    $display("scrub done busy_cnt=%0d", busy_cnt);
    chk("scrub_busy_end", 64'(bus.busy), 64'h0);
    chk("scrub_busy_len", 64'(busy_cnt), 64'd32);

    for (int i = 0; i < 32; i++) begin
      bus.dira = 5'(i); bus.dirb = 5'(31 - i);
      step();
      chk($sformatf("post_scrub%0d", i), {16'h0, bus.A, bus.B}, 64'h0);
    end

    // Reset in the middle of a scrub.
    bus.write = 1; bus.dira = 5'd20; bus.dirb = 5'd20; bus.data = 24'h202020;
    step();
    bus.write = 0; bus.clear = 1;
    step();
    bus.clear = 0;
    for (int j = 0; j < 10; j++) step();
    chk("pre_reset_A", 64'(bus.A), 64'h202020);
    chk("pre_reset_busy", 64'(bus.busy), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("mid-scrub reset busy=%0b A=%h", bus.busy, bus.A);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_A", 64'(bus.A), 64'h0);
    chk("rst_B", 64'(bus.B), 64'h0);
    chk("rst_aux", 64'(bus.aux_q), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.dira = 5'd20; bus.dirb = 5'd2;
    step();
    chk("after_rst_A", 64'(bus.A), 64'h0);
    chk("after_rst_B", 64'(bus.B), 64'h0);
    chk("after_rst_busy", 64'(bus.busy), 64'h0);
    bus.clear = 1;
    step();
    chk("reclear_busy", 64'(bus.busy), 64'h1);
    bus.clear = 0;
    busy_cnt = 1;
    for (int k = 0; k < 100 && bus.busy; k++) begin
      step();
      if (bus.busy) busy_cnt++;
    end
    chk("reclear_done", 64'(bus.busy), 64'h0);
    chk("reclear_len", 64'(busy_cnt), 64'd32);

    // Small-parameter instance.
    bus2.aux_we = 4'b0101; bus2.aux_d = 64'h4444_3333_2222_1111;
    step();
    chk("p2_aux0", bus2.aux_q, 64'h0000_3333_0000_1111);
    bus2.aux_we = 4'b1000; bus2.aux_d = 64'hDDDD_EEEE_EEEE_EEEE;
    step();
    chk("p2_aux1", bus2.aux_q, 64'hDDDD_3333_0000_1111);
    bus2.aux_we = '0;
    bus2.write = 1; bus2.dira = 3'd5; bus2.dirb = 3'd5; bus2.data = 16'hBEEF;
    step();
    chk("p2_wr_A", 64'(bus2.A), 64'hBEEF);
    chk("p2_wr_B", 64'(bus2.B), 64'hBEEF);
    bus2.write = 0; bus2.clear = 1;
    step();
    chk("p2_busy_start", 64'(bus2.busy), 64'h1);
    bus2.clear = 0;
    busy_cnt = 1;
    for (int k = 0; k < 20 && bus2.busy; k++) begin
      step();
      if (bus2.busy) busy_cnt++;
    end
    $display("p2 scrub busy_cnt=%0d", busy_cnt);
    chk("p2_busy_len", 64'(busy_cnt), 64'd8);
    step();
    chk("p2_post_A", 64'(bus2.A), 64'h0);
    chk("p2_aux_kept", bus2.aux_q, 64'hDDDD_3333_0000_1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_reg_bank.md
MEM_REG_BANK -- requirements
Module: mem_reg_bank

Interface
REQ-001 Parameter DATA_W, default 24, word width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W (default 32).
REQ-003 Parameter NAUX, default 2, number of independent auxiliary registers (RQ/RD-style).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 write  in  1  bank write enable.
REQ-007 dira  in  ADDR_W  port-A read address; also the write address.
REQ-008 dirb  in  ADDR_W  port-B read address.
REQ-009 data  in  DATA_W  write data.
REQ-010 A  out  DATA_W  port-A registered read data.
REQ-011 B  out  DATA_W  port-B registered read data.
REQ-012 aux_we  in  NAUX  per-register write enable, bit k selects aux register k.
REQ-013 aux_d  in  NAUX*DATA_W  aux write data, register k at bits [k*DATA_W +: DATA_W].
REQ-014 aux_q  out  NAUX*DATA_W  aux register contents, same packing.
REQ-015 clear  in  1  request to scrub the whole bank to zero.
REQ-016 busy  out  1  high while a scrub is in progress.

Function
REQ-017 Bank SHALL hold DEPTH words of DATA_W bits; aux registers SHALL be separate from the bank and unaffected by bank writes or scrub.
REQ-018 Write: in IDLE with write=1 at edge n, mem[dira] SHALL take data at edge n.
REQ-019 Reads: A and B SHALL be registered, latency 1: value after edge n = mem[dira]/mem[dirb] as sampled at edge n.
REQ-020 Bypass: if write=1 in IDLE at edge n, A SHALL take data; B SHALL take data when dirb==dira, otherwise mem[dirb] (write-first semantics).
REQ-021 Aux: for each k with aux_we[k]=1 at an edge, aux register k SHALL take its aux_d slice; other slices hold; aux_q is direct register output.
REQ-022 FSM states: IDLE, SCRUB. IDLE->SCRUB when clear=1 sampled in IDLE; scrub counter loads 0.
REQ-023 In SCRUB, each edge SHALL write zero to mem[counter] and increment counter; when counter==DEPTH-1 is written, next state SHALL be IDLE and counter returns to 0.
REQ-024 busy SHALL be 1 exactly while in SCRUB: asserted the edge after clear is sampled, held DEPTH cycles.
REQ-025 In SCRUB, write SHALL be ignored (no bank update, no bypass) and clear SHALL be ignored.
REQ-026 Reads SHALL remain active in SCRUB, returning current array contents (already-scrubbed entries read 0; the entry written this edge reads its pre-scrub value).
REQ-027 Aux writes SHALL operate normally in every state.
REQ-028 Address wrap: counter is ADDR_W+1 bits or terminal-compare based; no write beyond DEPTH-1.

Reset
REQ-029 rst_n=0 SHALL immediately zero all bank words, A, B, all aux registers, counter; busy=0; state IDLE.
REQ-030 Reset asserted mid-scrub SHALL abort the scrub; after release the block SHALL be in IDLE with busy=0 and all words zero.
REQ-031 First active edge after rst_n rises SHALL be processed normally.

Verification
REQ-032 Write 0xABCDEF to addr 3, next cycle dira=3, dirb=3 -> A=B=0xABCDEF one cycle later.
REQ-033 write=1, dira=7, data=0x123456, dirb=7 same cycle -> A=B=0x123456 after that edge; dirb=8 -> B=old mem[8].
REQ-034 Fill all 32 words nonzero, pulse clear -> busy high exactly 32 cycles, then all reads 0.
REQ-035 During scrub assert write to addr 31 with 0xFFFFFF -> ignored, mem[31]=0 after scrub; aux_we=2'b01, aux_d low=0x000055 -> aux_q low=0x000055, high unchanged.
REQ-036 Assert rst_n=0 at scrub cycle 10 -> busy=0, A=B=0, aux_q=0 immediately; after release clear re-accepted.
REQ-037 Parameter sweep DATA_W=16, ADDR_W=3, NAUX=4 -> scrub lasts 8 cycles, aux slices independent.
